elixirchip_es1_spu_op_arbiter: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_ARBITER -- requirements
Module: elixirchip_es1_spu_op_arbiter

---
 rtl/elixirchip_es1_spu_arb_pkg.sv | 13 +
 rtl/elixirchip_es1_spu_rr_arbiter.sv | 62 ++++++
 rtl/elixirchip_es1_spu_op_arbiter.sv | 147 ++++++++++++++
 tb/tb_elixirchip_es1_spu_op_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_arb_pkg.sv
// Shared definitions for the SPU op arbiter: id width helper and grant-counter type.
package elixirchip_es1_spu_arb_pkg;

  typedef logic [15:0] stat_cnt_t;

  localparam stat_cnt_t STAT_CNT_MAX = 16'hFFFF;

  // Width of a requester index; never below 1 so a single requester still has a port.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_rr_arbiter.sv
// Round-robin grant logic for the SPU op arbiter; owns the rotating priority pointer.
module elixirchip_es1_spu_rr_arbiter
  import elixirchip_es1_spu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_BITS = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  input  logic [N_REQ-1:0]   s_valid,
  output logic [N_REQ-1:0]   s_ready,
  output logic               grant,
  output logic [ID_BITS-1:0] grant_id
);

  logic [ID_BITS-1:0] rr_ptr;
  logic [ID_BITS-1:0] win_id;
  logic [ID_BITS-1:0] next_ptr;
  logic               win_found;
  logic               enable;

  assign enable = cke & ~reset;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!win_found && s_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_BITS'(idx);
      end
    end
  end

  generate
    if (N_REQ == 1) begin : g_single
      assign s_ready = enable;
    end else begin : g_multi
      assign s_ready = (enable && win_found) ? (N_REQ'(1) << win_id) : '0;
    end
  endgenerate

  assign grant    = |(s_valid & s_ready);
  assign grant_id = win_id;
  assign next_ptr = (win_id == ID_BITS'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (cke && grant) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Shares one pipelined op unit among N_REQ requesters and routes results back by tag.
// Define ELIXIRCHIP_ES1_SPU_ARB_STAT_EN to add saturating per-requester grant counters.
module elixirchip_es1_spu_op_arbiter
  import elixirchip_es1_spu_arb_pkg::*;
#(
  parameter int    N_REQ      = 4,
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic [N_REQ-1:0]              s_valid,
  input  logic [N_REQ-1:0]              s_clear,
  input  logic [N_REQ*DATA_BITS-1:0]    s_data,
  output logic [N_REQ-1:0]              s_ready,
  output logic [DATA_BITS-1:0]          op_data,
  output logic                          op_clear,
  output logic                          op_valid,
  input  logic [DATA_BITS-1:0]          op_result,
  output logic [DATA_BITS-1:0]          m_data,
  output logic [N_REQ-1:0]              m_valid,
  output logic [id_width(N_REQ)-1:0]    m_id
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
  ,
  output logic [N_REQ*16-1:0]           stat_grants
`endif
);

  localparam int ID_BITS = id_width(N_REQ);

  generate
    if (N_REQ < 1 || N_REQ > 16 || LATENCY < 0 || DEVICE == "" ||
        !(SIMULATION == "true" || SIMULATION == "false") ||
        !(DEBUG == "true" || DEBUG == "false")) begin : g_param_check
      $error("elixirchip_es1_spu_op_arbiter: illegal parameter value");
    end
  endgenerate

  logic               xfer;
  logic [ID_BITS-1:0] grant_id;
  logic [ID_BITS-1:0] op_id;
  logic               tail_valid;
  logic [ID_BITS-1:0] tail_id;

  elixirchip_es1_spu_rr_arbiter #(
    .N_REQ   (N_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .grant    (xfer),
    .grant_id (grant_id)
  );

  // Issue stage
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_clear <= 1'b0;
    end else if (cke) begin
      op_valid <= xfer;
      op_clear <= xfer & s_clear[grant_id];
    end
  end

  // Operand and owner hold their last value when nothing is issued.
  always_ff @(posedge clk) begin
    if (cke && xfer) begin
      op_data <= s_data[grant_id*DATA_BITS +: DATA_BITS];
      op_id   <= grant_id;
    end
  end

  // Tag pipeline mirrors the op unit latency so results find their owner.
  generate
    if (LATENCY == 0) begin : g_no_tag
      assign tail_valid = op_valid;
      assign tail_id    = op_id;
    end else begin : g_tag
      logic [LATENCY-1:0] tag_valid_q;
      logic [ID_BITS-1:0] tag_id_q [LATENCY];

      always_ff @(posedge clk) begin
        if (reset) begin
          tag_valid_q <= '0;
        end else if (cke) begin
          tag_valid_q[0] <= op_valid;
          for (int i = 1; i < LATENCY; i++) begin
            tag_valid_q[i] <= tag_valid_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (cke) begin
          tag_id_q[0] <= op_id;
          for (int i = 1; i < LATENCY; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
          end
        end
      end

      assign tail_valid = tag_valid_q[LATENCY-1];
      assign tail_id    = tag_id_q[LATENCY-1];
    end
  endgenerate

  always_comb begin
    m_valid = '0;
    if (tail_valid) begin
      m_valid[tail_id] = 1'b1;
    end
  end

  assign m_id   = tail_id;
  assign m_data = op_result;

`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
  stat_cnt_t stat_q [N_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else if (cke) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (s_valid[i] && s_ready[i] && stat_q[i] != STAT_CNT_MAX) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat_out
    assign stat_grants[g*16 +: 16] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Scoreboard bench: two arbiters (LATENCY 2 and 0) share stimulus; monitors check results.
module tb_elixirchip_es1_spu_op_arbiter;

  logic        clk;
  logic        reset;
  logic        cke;
  logic [3:0]  s_valid;
  logic [3:0]  s_clear;
  logic [31:0] s_data;

  logic [3:0]  s_ready2, s_ready0;
  logic [7:0]  op_data2, op_data0;
  logic        op_clear2, op_clear0;
  logic        op_valid2, op_valid0;
  logic [7:0]  op_result2, op_result0;
  logic [7:0]  m_data2, m_data0;
  logic [3:0]  m_valid2, m_valid0;
  logic [1:0]  m_id2, m_id0;
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
  logic [63:0] stat2, stat0;
`endif

  elixirchip_es1_spu_op_arbiter #(
    .N_REQ     (4),
    .LATENCY   (2),
    .DATA_BITS (8)
  ) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .s_valid   (s_valid),
    .s_clear   (s_clear),
    .s_data    (s_data),
    .s_ready   (s_ready2),
    .op_data   (op_data2),
    .op_clear  (op_clear2),
    .op_valid  (op_valid2),
    .op_result (op_result2),
    .m_data    (m_data2),
    .m_valid   (m_valid2),
    .m_id      (m_id2)
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
    ,
    .stat_grants (stat2)
`endif
  );

  elixirchip_es1_spu_op_arbiter #(
    .N_REQ     (4),
    .LATENCY   (0),
    .DATA_BITS (8)
  ) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .s_valid   (s_valid),
    .s_clear   (s_clear),
    .s_data    (s_data),
    .s_ready   (s_ready0),
    .op_data   (op_data0),
    .op_clear  (op_clear0),
    .op_valid  (op_valid0),
    .op_result (op_result0),
    .m_data    (m_data0),
    .m_valid   (m_valid0),
    .m_id      (m_id0)
`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
    ,
    .stat_grants (stat0)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared op unit models: pure delay lines, so results equal the issued operand.
  logic [7:0] pipe_a, pipe_b;
  always @(posedge clk) begin
    if (cke) begin
      pipe_a <= op_data2;
      pipe_b <= pipe_a;
    end
  end
  assign op_result2 = pipe_b;
  assign op_result0 = op_data0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       clr;
    int         due;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ecyc     = 0;
  bit   mon_en   = 1'b0;

  // Counts enabled cycles; result deadlines are expressed in this time base.
  always @(posedge clk) begin
    if (cke) ecyc <= ecyc + 1;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (enabled cycle %0d)", name, act, exp, ecyc);
  endfunction

  always @(negedge clk) begin
    if (mon_en && cke) begin
      if (q2.size() > 0 && q2[0].due == ecyc) begin
        exp_t e;
        e = q2.pop_front();
        check("lat2_m_valid", 32'(m_valid2), 32'(1) << e.id);
        check("lat2_m_id", 32'(m_id2), 32'(e.id));
        check("lat2_m_data", 32'(m_data2), 32'(e.data));
      end else begin
        check("lat2_m_valid_idle", 32'(m_valid2), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && cke) begin
      if (q0.size() > 0 && q0[0].due == ecyc) begin
        exp_t e;
        e = q0.pop_front();
        check("lat0_m_valid", 32'(m_valid0), 32'(1) << e.id);
        check("lat0_m_id", 32'(m_id0), 32'(e.id));
        check("lat0_m_data", 32'(m_data0), 32'(e.data));
        check("lat0_op_clear", 32'(op_clear0), 32'(e.clr));
      end else begin
        check("lat0_m_valid_idle", 32'(m_valid0), 32'd0);
        check("lat0_op_clear_idle", 32'(op_clear0), 32'd0);
      end
    end
  end

  // One cycle of stimulus; exp_id is the hand-computed winner or -1 for no grant.
  task automatic step(input logic rst, input logic ce, input logic [3:0] v,
                      input logic [3:0] clr, input int exp_id);
    logic [31:0] exp_rdy;
    exp_t        e;
    reset   = rst;
    cke     = ce;
    s_valid = v;
    s_clear = clr;
    #1;
    exp_rdy = (exp_id >= 0) ? (32'(1) << exp_id) : 32'd0;
    check("lat2_s_ready", 32'(s_ready2), exp_rdy);
    check("lat0_s_ready", 32'(s_ready0), exp_rdy);
    if (exp_id >= 0) begin
      e.id   = exp_id;
      e.data = s_data[exp_id*8 +: 8];
      e.clr  = clr[exp_id];
      e.due  = ecyc + 3;
      q2.push_back(e);
      e.due  = ecyc + 1;
      q0.push_back(e);
    end
    if (rst) begin
      // Tags still in flight past this cycle are discarded by the reset.
      while (q2.size() > 0 && q2[q2.size()-1].due > ecyc) q2.delete(q2.size() - 1);
      while (q0.size() > 0 && q0[q0.size()-1].due > ecyc) q0.delete(q0.size() - 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_valid = '0;
    s_clear = '0;
    s_data  = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 4'b1111, 4'b0000, -1);
    step(1'b1, 1'b1, 4'b1111, 4'b0000, -1);
    check("reset_op_valid2", 32'(op_valid2), 32'd0);
    check("reset_op_clear2", 32'(op_clear2), 32'd0);
    check("reset_m_valid2", 32'(m_valid2), 32'd0);
    check("reset_op_valid0", 32'(op_valid0), 32'd0);
    check("reset_m_valid0", 32'(m_valid0), 32'd0);
    mon_en = 1'b1;

    // All four requesting: strict rotation.
    s_data = 32'h44332211;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b1111, 4'b0000, i % 4);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, -1);

    // Lone continuous requester is granted every cycle.
    s_data = 32'h445A2211;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b0100, 4'b0000, 2);

    // Clear from requester 1 leaves pointer at 2, then 1010 alternates with a stall.
    s_data = 32'hA4A3A2A1;
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 1);
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 3);
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 3);
    step(1'b0, 1'b0, 4'b1010, 4'b0000, -1);
    step(1'b0, 1'b0, 4'b1010, 4'b0000, -1);
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, -1);

    // Reset with two tags in flight, then pointer restarts at 0.
    s_data = 32'hB4B3B2B1;
    step(1'b0, 1'b1, 4'b0010, 4'b0000, 1);
    step(1'b0, 1'b1, 4'b0010, 4'b0000, 1);
    step(1'b1, 1'b1, 4'b0000, 4'b0000, -1);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 0);
    step(1'b0, 1'b1, 4'b1110, 4'b0000, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, -1);

`ifdef ELIXIRCHIP_ES1_SPU_ARB_STAT_EN
    step(1'b1, 1'b1, 4'b0000, 4'b0000, -1);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 4'b0001, 4'b0000, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, -1);
    check("stat2_req0", 32'(stat2[15:0]), 32'h0000FFFF);
    check("stat2_others", 32'(|stat2[63:16]), 32'd0);
    check("stat0_req0", 32'(stat0[15:0]), 32'h0000FFFF);
`endif

    check("lat2_queue_drained", 32'(q2.size()), 32'd0);
    check("lat0_queue_drained", 32'(q0.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
